wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter directly upstream of the register file. It merges results from the ALU (single-cycle) and the load path (variable latency) into the register file's single write port. Load results are held in a small FIFO. The arbiter issues at most one registered write per cycle and reports pending writes to decode for hazard stalls.

## Interface
Parameters:
- PW, 4, register pointer width; write address is PW+1 bits to match the register file write port.
- DEPTH, 4, load-result FIFO depth; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU result offered this cycle.
- alu_addr  input  PW+1  ALU destination register.
- alu_data  input  8  ALU result.
- alu_ready  output  1  ALU result accepted this cycle (combinational).
- mem_valid  input  1  load result offered.
- mem_addr  input  PW+1  load destination register.
- mem_data  input  8  load data.
- mem_ready  output  1  FIFO can accept a load result (combinational).
- wr_en  output  1  register-file write enable (registered).
- wr_addr  output  PW+1  register-file write address (registered).
- dat_in  output  8  register-file write data (registered).
- chk_addr  input  PW+1  register number queried by decode.
- pending  output  1  a write to chk_addr is queued or in the output register (combinational).
- idle  output  1  FIFO empty and wr_en low.

## Operation
- A transfer occurs on a port when valid and ready are both high in the same cycle. Data is sampled on that edge.
- mem_ready = (count < DEPTH). A load that arrives while the FIFO is full is not accepted, even if the FIFO is popped in the same cycle.
- Grant is evaluated each cycle, in priority order:
  - FULL: count == DEPTH. Pop the FIFO head. alu_ready = 0.
  - ALU: count < DEPTH and alu_valid. Take the ALU result. alu_ready = 1.
  - DRAIN: no alu_valid and count > 0. Pop the FIFO head.
  - NONE: no write next cycle.
- The selected request is registered into wr_addr/dat_in, and wr_en is set for the next cycle.
- With NONE, wr_en = 0 and wr_addr/dat_in hold their previous values.
- Simultaneous push and pop (count < DEPTH): count is unchanged and the head advances. The pushed entry is never bypassed past older entries.
- The FIFO is strictly in order. Ordering between ALU writes and queued loads is not preserved.
  - Decode must stall any instruction whose destination or source has pending = 1.
- pending is the OR of address compares over all valid FIFO entries plus (wr_en and wr_addr == chk_addr). It does not include the current-cycle alu/mem inputs.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits, range 0..DEPTH.

## Timing
- Reset values: wr_en = 0, wr_addr = 0, dat_in = 0, count = 0, pointers = 0. After reset, alu_ready = 1 (FIFO empty), mem_ready = 1, pending = 0, idle = 1.
- Reset mid-operation discards all queued loads and any registered write. wr_en is 0 in the cycle after reset is sampled high.
- Reset has priority over push and pop in the same cycle.
- ALU latency: accepted at edge N, wr_en high during cycle N+1, and the register file commits at edge N+1.
- Load latency: 1 cycle best case (FIFO empty, no ALU). Worst case is bounded by DEPTH cycles once the FIFO is full, because FULL preempts the ALU.
- Throughput: one write per cycle, never two.

## Structure
- Package wb_pkg:
  - wb_req_t packed struct {addr[PW:0], data[7:0]}.
  - localparams for default PW and DEPTH.
  - grant enum {G_NONE, G_ALU, G_FIFO}.
- Sub-module wb_fifo holds the circular buffer of wb_req_t.
  - Ports: push, pop, head, count, full, empty, plus a per-entry valid/address vector for the pending compare.
  - Arbitration and the output register live in wb_arbiter.

## Test plan
- Reset, then idle: no valid inputs for 5 cycles -> wr_en = 0 throughout, idle = 1, pending = 0 for every chk_addr.
- ALU write: alu 0x05 -> r3 at edge N -> wr_en = 1, wr_addr = 3, dat_in = 0x05 in cycle N+1; pending for chk_addr = 3 is high in cycle N+1 only.
- Contention: alu (r1, 0x11) and mem (r2, 0x22) valid in the same cycle -> ALU writes first; the load writes the following cycle when the ALU is idle.
- Full FIFO: 4 loads (0xA0..0xA3 -> r4..r7) pushed while the ALU streams continuously -> at count == 4, alu_ready = 0 and mem_ready = 0. Loads drain in order 0xA0..0xA3 on consecutive cycles, and alu_ready then returns to 1.
- Simultaneous push/pop with count = 2 -> count stays 2 and write order matches arrival order. A push attempt at count = 4 with a pop in the same cycle is rejected (mem_ready = 0).
- Reset asserted with 3 loads queued -> next cycle: wr_en = 0, idle = 1, pending = 0; the queued loads are never written.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: request layout, default sizing and grant encoding.
package wb_pkg;

    localparam int WB_PW    = 4;
    localparam int WB_DEPTH = 4;

    typedef struct packed {
        logic [WB_PW:0] addr;
        logic [7:0]     data;
    } wb_req_t;

    typedef enum logic [1:0] {
        G_NONE,
        G_ALU,
        G_FIFO
    } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of load results; exposes every slot and its validity so the
// arbiter can report pending writes without walking the queue.
module wb_fifo #(
    parameter  int W     = 13,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              din,
    output logic [W-1:0]              head,
    output logic [AW:0]               count,
    output logic                      full,
    output logic                      empty,
    output logic [DEPTH-1:0]          ent_valid,
    output logic [DEPTH-1:0][W-1:0]   ent_data
);

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   off;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; a slot only matters while count says it is occupied.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        ent_valid = '0;
        ent_data  = '0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off          = AW'(i) - rd_ptr;
            ent_valid[i] = ({1'b0, off} < count);
            ent_data[i]  = mem[i];
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges single-cycle ALU results and queued load results into one registered register-file
// write per cycle, and flags destinations that still have a write in flight.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int PW    = WB_PW,
    parameter int DEPTH = WB_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    input  logic [PW:0]   alu_addr,
    input  logic [7:0]    alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [PW:0]   mem_addr,
    input  logic [7:0]    mem_data,
    output logic          mem_ready,
    output logic          wr_en,
    output logic [PW:0]   wr_addr,
    output logic [7:0]    dat_in,
    input  logic [PW:0]   chk_addr,
    output logic          pending,
    output logic          idle
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [PW:0] addr;
        logic [7:0]  data;
    } req_t;

    localparam int W = $bits(req_t);

    req_t                   head;
    req_t                   ent;
    logic [AW:0]            count;
    logic                   full;
    logic                   empty;
    logic [DEPTH-1:0]       ent_valid;
    logic [DEPTH-1:0][W-1:0] ent_data;
    grant_e                 grant;

    assign alu_ready = (count < (AW+1)'(DEPTH));
    assign mem_ready = (count < (AW+1)'(DEPTH));

    wb_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (mem_valid && mem_ready),
        .pop       (grant == G_FIFO),
        .din       ({mem_addr, mem_data}),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .ent_valid (ent_valid),
        .ent_data  (ent_data)
    );

    // A full queue preempts the ALU so load latency stays bounded.
    always_comb begin
        grant = G_NONE;
        if (full)           grant = G_FIFO;
        else if (alu_valid) grant = G_ALU;
        else if (!empty)    grant = G_FIFO;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            dat_in  <= '0;
        end else begin
            wr_en <= (grant != G_NONE);
            case (grant)
                G_ALU: begin
                    wr_addr <= alu_addr;
                    dat_in  <= alu_data;
                end
                G_FIFO: begin
                    wr_addr <= head.addr;
                    dat_in  <= head.data;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pending = wr_en && (wr_addr == chk_addr);
        ent     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent = req_t'(ent_data[i]);
            if (ent_valid[i] && (ent.addr == chk_addr)) pending = 1'b1;
        end
    end

    assign idle = empty && !wr_en;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int PW    = WB_PW;
    localparam int DEPTH = WB_DEPTH;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid;
    logic [PW:0]   alu_addr;
    logic [7:0]    alu_data;
    logic          alu_ready;
    logic          mem_valid;
    logic [PW:0]   mem_addr;
    logic [7:0]    mem_data;
    logic          mem_ready;
    logic          wr_en;
    logic [PW:0]   wr_addr;
    logic [7:0]    dat_in;
    logic [PW:0]   chk_addr;
    logic          pending;
    logic          idle;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queue of loads plus the expected registered write.
    wb_req_t       q[$];
    logic          m_en;
    logic [PW:0]   m_addr;
    logic [7:0]    m_data;

    always #5 clk = ~clk;

    wb_arbiter #(.PW(PW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .dat_in    (dat_in),
        .chk_addr  (chk_addr),
        .pending   (pending),
        .idle      (idle)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic full_q;
        logic pend;
        full_q = (q.size() == DEPTH);
        pend   = m_en && (m_addr == chk_addr);
        foreach (q[i]) if (q[i].addr == chk_addr) pend = 1'b1;
        check("alu_ready", 32'(alu_ready), 32'(!full_q));
        check("mem_ready", 32'(mem_ready), 32'(!full_q));
        check("wr_en",     32'(wr_en),     32'(m_en));
        check("wr_addr",   32'(wr_addr),   32'(m_addr));
        check("dat_in",    32'(dat_in),    32'(m_data));
        check("pending",   32'(pending),   32'(pend));
        check("idle",      32'(idle),      32'((q.size() == 0) && !m_en));
    endtask

    task automatic update_model();
        wb_req_t r;
        logic    full_q;
        if (reset) begin
            q.delete();
            m_en   = 1'b0;
            m_addr = '0;
            m_data = '0;
        end else begin
            full_q = (q.size() == DEPTH);
            if (full_q || (!alu_valid && q.size() > 0)) begin
                r      = q.pop_front();
                m_en   = 1'b1;
                m_addr = r.addr;
                m_data = r.data;
            end else if (alu_valid) begin
                m_en   = 1'b1;
                m_addr = alu_addr;
                m_data = alu_data;
            end else begin
                m_en = 1'b0;
            end
            if (mem_valid && !full_q) q.push_back('{addr: mem_addr, data: mem_data});
        end
    endtask

    task automatic step(input logic r, input logic av, input logic [PW:0] aa, input logic [7:0] ad,
                        input logic mv, input logic [PW:0] ma, input logic [7:0] md,
                        input logic [PW:0] ca);
        reset     = r;
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        mem_valid = mv;
        mem_addr  = ma;
        mem_data  = md;
        chk_addr  = ca;
        @(negedge clk);
        compare_model();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step(input logic [PW:0] ca);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ca);
    endtask

    initial begin
        reset     = 1'b1;
        alu_valid = 1'b0;
        alu_addr  = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        chk_addr  = '0;
        m_en      = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_wr_en",     32'(wr_en),     32'd0);
        check("rst_wr_addr",   32'(wr_addr),   32'd0);
        check("rst_dat_in",    32'(dat_in),    32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd1);
        check("rst_mem_ready", 32'(mem_ready), 32'd1);
        check("rst_pending",   32'(pending),   32'd0);
        check("rst_idle",      32'(idle),      32'd1);

        for (int i = 0; i < 5; i++) begin
            idle_step((PW+1)'(i * 5));
            check("idle_wr_en", 32'(wr_en), 32'd0);
            check("idle_idle",  32'(idle),  32'd1);
        end

        // Single ALU write to r3.
        step(1'b0, 1'b1, 5'd3, 8'h05, 1'b0, '0, '0, 5'd3);
        check("alu_wr_en",   32'(wr_en),   32'd1);
        check("alu_wr_addr", 32'(wr_addr), 32'd3);
        check("alu_dat_in",  32'(dat_in),  32'h05);
        check("alu_pend_n1", 32'(pending), 32'd1);
        idle_step(5'd3);
        check("alu_wr_en_n2", 32'(wr_en),   32'd0);
        check("alu_pend_n2",  32'(pending), 32'd0);

        // ALU and load in the same cycle: ALU first, load next.
        step(1'b0, 1'b1, 5'd1, 8'h11, 1'b1, 5'd2, 8'h22, 5'd2);
        check("cont_first_addr", 32'(wr_addr), 32'd1);
        check("cont_first_data", 32'(dat_in),  32'h11);
        check("cont_load_pend",  32'(pending), 32'd1);
        idle_step(5'd2);
        check("cont_second_en",   32'(wr_en),   32'd1);
        check("cont_second_addr", 32'(wr_addr), 32'd2);
        check("cont_second_data", 32'(dat_in),  32'h22);
        idle_step(5'd0);

        // Fill the queue while the ALU streams.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, (PW+1)'(8 + i), 8'(8'h50 + i), 1'b1, (PW+1)'(4 + i), 8'(8'hA0 + i), 5'd7);
            check("fill_alu_data", 32'(dat_in), 32'(8'h50 + i));
        end
        check("full_alu_ready", 32'(alu_ready), 32'd0);
        check("full_mem_ready", 32'(mem_ready), 32'd0);
        // Rejected ALU and load at count == DEPTH while the head pops.
        step(1'b0, 1'b1, 5'd9, 8'h99, 1'b1, 5'd12, 8'hEE, 5'd12);
        check("drain0_data", 32'(dat_in),  32'hA0);
        check("drain0_addr", 32'(wr_addr), 32'd4);
        for (int i = 1; i < 4; i++) begin
            idle_step(5'd12);
            check("drain_en",   32'(wr_en),   32'd1);
            check("drain_addr", 32'(wr_addr), 32'(4 + i));
            check("drain_data", 32'(dat_in),  32'(8'hA0 + i));
        end
        check("after_drain_alu_ready", 32'(alu_ready), 32'd1);
        idle_step(5'd12);
        check("rejected_never_written", 32'(wr_en), 32'd0);

        // Simultaneous push and pop at count == 2.
        step(1'b0, 1'b1, 5'd20, 8'hC0, 1'b1, 5'd9,  8'hB0, 5'd0);
        step(1'b0, 1'b1, 5'd21, 8'hC1, 1'b1, 5'd10, 8'hB1, 5'd0);
        step(1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 5'd11, 8'hB2, 5'd0);
        check("pp_first", 32'(dat_in), 32'hB0);
        idle_step(5'd0);
        check("pp_second", 32'(dat_in), 32'hB1);
        idle_step(5'd0);
        check("pp_third", 32'(dat_in), 32'hB2);
        idle_step(5'd0);
        check("pp_done", 32'(wr_en), 32'd0);

        // Reset with three loads queued.
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 5'd30, 8'(i), 1'b1, (PW+1)'(16 + i), 8'(8'hD0 + i), 5'd17);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 5'd17);
        check("rstq_wr_en",   32'(wr_en),   32'd0);
        check("rstq_idle",    32'(idle),    32'd1);
        check("rstq_pending", 32'(pending), 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle_step((PW+1)'(16 + i));
            check("rstq_no_write", 32'(wr_en), 32'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 59) == 0),
                 1'($urandom_range(0, 1)),
                 (PW+1)'($urandom_range(0, 7)),
                 8'($urandom),
                 1'($urandom_range(0, 9) < 6),
                 (PW+1)'($urandom_range(0, 7)),
                 8'($urandom),
                 (PW+1)'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
